bcd_serial_add_ctrl: RTL and testbench



---
 rtl/bcd_serial_add_ctrl_pkg.sv | 18 +
 rtl/bcd_serial_add_ctrl_if.sv | 25 ++
 rtl/bcd_serial_add_ctrl_digit_add.sv | 25 ++
 rtl/bcd_serial_add_ctrl.sv | 109 ++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/bcd_serial_add_ctrl_pkg.sv
// Shared definitions for the serial BCD add/subtract datapath.
package bcd_pkg;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_ADJ = 4'd6;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   // Nines complement of one digit, wrapping modulo 16 for illegal digits.
   function automatic logic [3:0] nines_comp(input logic [3:0] digit);
      return BCD_MAX - digit;
   endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// Operand/result bundle between the operand registers, the sequencer and the result register.
interface bcd_serial_add_ctrl_if #(
   parameter int NDIG = 4
);
   logic                start;
   logic                sub;
   logic [4*NDIG-1:0]   a;
   logic [4*NDIG-1:0]   b;
   logic                cin;
   logic                busy;
   logic                done;
   logic [4*NDIG-1:0]   sum;
   logic                cout;
   logic                invalid;

   modport master (
      output start, sub, a, b, cin,
      input  busy, done, sum, cout, invalid
   );

   modport slave (
      input  start, sub, a, b, cin,
      output busy, done, sum, cout, invalid
   );
endinterface

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// One-digit BCD adder with decimal adjust; shared by every digit position.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       c,
   output logic [3:0] s,
   output logic       carry
);

   logic [4:0] w;

   always_comb begin
      w     = {1'b0, a} + {1'b0, b} + {4'b0000, c};
      s     = w[3:0];
      carry = 1'b0;
      if (w > {1'b0, BCD_MAX}) begin
         // Low nibble of (w + 6); the 4-bit add wraps exactly like mod 16.
         s     = w[3:0] + BCD_ADJ;
         carry = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD add/subtract sequencer: one digit pair per clock, LSD first.
module bcd_serial_add_ctrl
   import bcd_pkg::*;
#(
   parameter  int NDIG = 4,
   localparam int IDXW = $clog2(NDIG) + 1
) (
   input  logic clk,
   input  logic rst,
   bcd_serial_add_ctrl_if.slave bus
);

   state_e             state_q;
   logic [IDXW-1:0]    idx_q;
   logic [4*NDIG-1:0]  a_q;
   logic [4*NDIG-1:0]  b_q;
   logic               sub_q;
   logic               carry_q;
   logic [4*NDIG-1:0]  sum_q;
   logic               cout_q;
   logic               inv_q;
   logic               busy_q;
   logic               done_q;

   logic [3:0]         a_dig;
   logic [3:0]         b_raw;
   logic [3:0]         b_eff;
   logic [3:0]         sum_d;
   logic               carry_d;
   logic               bad_d;

   // Operand registers shift right so the digit in play is always in [3:0].
   always_comb begin
      a_dig = a_q[3:0];
      b_raw = b_q[3:0];
      b_eff = sub_q ? nines_comp(b_raw) : b_raw;
      bad_d = (a_dig > BCD_MAX) | (b_raw > BCD_MAX);
   end

   bcd_digit_add u_digit (
      .a     (a_dig),
      .b     (b_eff),
      .c     (carry_q),
      .s     (sum_d),
      .carry (carry_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         inv_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  sub_q   <= bus.sub;
                  carry_q <= bus.sub ? 1'b1 : bus.cin;
                  idx_q   <= '0;
                  inv_q   <= 1'b0;
                  sum_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               for (int unsigned i = 0; i < NDIG; i++) begin
                  if (idx_q == IDXW'(i)) sum_q[i*4 +: 4] <= sum_d;
               end
               carry_q <= carry_d;
               inv_q   <= inv_q | bad_d;
               a_q     <= a_q >> 4;
               b_q     <= b_q >> 4;
               idx_q   <= idx_q + IDXW'(1);
               if (idx_q == IDXW'(NDIG - 1)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cout_q  <= carry_d;
                  state_q <= DONE;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.sum     = sum_q;
   assign bus.cout    = cout_q;
   assign bus.invalid = inv_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed self-checking bench for the serial BCD add/subtract sequencer.
module tb_bcd_serial_add_ctrl;

   localparam int NDIG = 4;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_fail;

   bcd_serial_add_ctrl_if #(.NDIG(NDIG)) bus ();

   bcd_serial_add_ctrl #(.NDIG(NDIG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Launch one operation and check latency, busy width, pulse width and results.
   task automatic run_op(input string tag, input logic sub, input logic [15:0] a,
                         input logic [15:0] b, input logic cin, input logic [15:0] exp_sum,
                         input logic exp_cout, input logic exp_inv);
      int busy_n;
      int done_at;
      int overlap;
      busy_n  = 0;
      done_at = 0;
      overlap = 0;
      bus.start = 1'b1;
      bus.sub   = sub;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = cin;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = 16'hFFFF;
      bus.b     = 16'hFFFF;
      for (int k = 1; k <= 20; k++) begin
         if (bus.busy) busy_n++;
         if (bus.busy && bus.done) overlap++;
         if (bus.done) begin
            done_at = k;
            break;
         end
         @(negedge clk);
      end
      check_eq({tag, "_done_cycle"}, 32'(done_at), 32'(NDIG + 1));
      check_eq({tag, "_busy_cycles"}, 32'(busy_n), 32'(NDIG));
      check_eq({tag, "_overlap"}, 32'(overlap), 32'd0);
      check_eq({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
      check_eq({tag, "_cout"}, 32'(bus.cout), 32'(exp_cout));
      check_eq({tag, "_invalid"}, 32'(bus.invalid), 32'(exp_inv));
      @(negedge clk);
      check_eq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
      check_eq({tag, "_sum_hold"}, 32'(bus.sum), 32'(exp_sum));
   endtask

   initial begin
      int dcount;
      logic [15:0] sum_at_done;
      logic cout_at_done;
      n_chk     = 0;
      n_fail    = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_done", 32'(bus.done), 32'd0);
      check_eq("rst_sum", 32'(bus.sum), 32'd0);
      check_eq("rst_cout", 32'(bus.cout), 32'd0);
      check_eq("rst_invalid", 32'(bus.invalid), 32'd0);
      @(negedge clk);

      run_op("add_ripple", 1'b0, 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);
      run_op("add_ovf",    1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("add_cin",    1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
      run_op("sub_pos",    1'b1, 16'h0500, 16'h0123, 1'b0, 16'h0377, 1'b1, 1'b0);
      run_op("sub_neg",    1'b1, 16'h0123, 16'h0500, 1'b1, 16'h9623, 1'b0, 1'b0);
      run_op("inv_a",      1'b0, 16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1);
      run_op("inv_clear",  1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0);
      run_op("inv_b",      1'b0, 16'h0000, 16'h00B0, 1'b0, 16'h0110, 1'b0, 1'b1);

      // Extra start pulses during RUN and during DONE must be dropped.
      bus.start = 1'b1;
      bus.sub   = 1'b1;
      bus.a     = 16'h0500;
      bus.b     = 16'h0123;
      @(negedge clk);
      bus.start = 1'b0;
      bus.sub   = 1'b0;
      bus.a     = 16'h1111;
      bus.b     = 16'h2222;
      dcount       = 0;
      sum_at_done  = '0;
      cout_at_done = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         if (bus.done) begin
            dcount++;
            sum_at_done  = bus.sum;
            cout_at_done = bus.cout;
         end
         bus.start = (c == 2) || bus.done;
         @(negedge clk);
      end
      bus.start = 1'b0;
      check_eq("ign_done_count", 32'(dcount), 32'd1);
      check_eq("ign_sum", 32'(sum_at_done), 32'h0377);
      check_eq("ign_cout", 32'(cout_at_done), 32'd1);
      check_eq("ign_busy_after", 32'(bus.busy), 32'd0);
      check_eq("ign_sum_hold", 32'(bus.sum), 32'h0377);

      // Reset in the second RUN cycle aborts without a done.
      bus.start = 1'b1;
      bus.sub   = 1'b0;
      bus.a     = 16'h1234;
      bus.b     = 16'h1111;
      bus.cin   = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_eq("abort_busy", 32'(bus.busy), 32'd0);
      check_eq("abort_done", 32'(bus.done), 32'd0);
      check_eq("abort_sum", 32'(bus.sum), 32'd0);
      check_eq("abort_cout", 32'(bus.cout), 32'd0);
      rst    = 1'b0;
      dcount = 0;
      for (int c = 0; c < 8; c++) begin
         if (bus.done || bus.busy) dcount++;
         @(negedge clk);
      end
      check_eq("abort_quiet", 32'(dcount), 32'd0);
      run_op("post_abort", 1'b0, 16'h0999, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
